// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parameterised inter-stage pipeline register.
//   Carries LANES data lanes of LANE_W bits plus an AUX_W side field from one
//   stage to the next. It provides a valid/ready handshake, synchronous flush,
//   and bubble zeroing. An optional 2-entry skid buffer registers in_ready, so
//   a downstream stall never reaches upstream combinationally.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (beats flush and handshakes)
//   flush      synchronous kill of all held entries
//   in_valid   upstream has data
//   in_ready   stage accepts data this cycle
//   in_data    lane i at bits [i*LANE_W +: LANE_W]
//   in_aux     side field
//   out_valid  output entry valid
//   out_ready  downstream consumes
//   out_data   registered lanes
//   out_aux    registered side field
//   occupancy  entries held (0..2; max 1 when SKID=0)

// One lane's storage: the output register plus the skid register behind it.
// PASS lanes keep tracking the input while the stage is killed. This lets a
// value such as pcplus stay live across a reset or flush.
module pipe_stage_lane #(
  parameter int W           = 32,
  parameter bit PASS        = 1'b0,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic         clk,
  input  logic         kill,
  input  logic         loadOut,
  input  logic         loadSkid,
  input  logic         selSkid,
  input  logic         outValid,
  input  logic [W-1:0] inD,
  output logic [W-1:0] outD
);
  logic [W-1:0] outQ;
  logic [W-1:0] skidQ;

  always_ff @(posedge clk) begin
    if (kill)         outQ <= PASS ? inD : '0;
    else if (loadOut) outQ <= selSkid ? skidQ : inD;
  end

  // The skid data needs no clear. A killed entry is dropped through its valid bit.
  always_ff @(posedge clk) begin
    if (loadSkid) skidQ <= inD;
  end

  // A bubble on the instr lane then reads as all-zero, which is a NOP.
  assign outD = (ZERO_BUBBLE && !PASS && !outValid) ? '0 : outQ;
endmodule

module pipe_stage_reg #(
  parameter int               LANES       = 4,
  parameter int               LANE_W      = 32,
  parameter int               AUX_W       = 2,
  parameter logic [LANES-1:0] PASS_MASK   = 4'b1000,
  parameter int               SKID        = 1,
  parameter bit               ZERO_BUBBLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [AUX_W-1:0]        in_aux,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [AUX_W-1:0]        out_aux,
  output logic [1:0]              occupancy
);
  if (SKID != 0 && SKID != 1) begin : gBadSkid
    $error("pipe_stage_reg: SKID must be 0 or 1");
  end
  if (AUX_W < 1) begin : gBadAux
    $error("pipe_stage_reg: AUX_W must be >= 1");
  end

  logic outValid, skidValid, inReadyQ;
  logic outValidNxt, skidValidNxt;
  logic kill, acc, cons, loadOut, loadSkid;

  assign kill = rst | flush;
  assign in_ready = (SKID == 1) ? inReadyQ : (~outValid | out_ready);
  assign acc  = in_valid & in_ready;
  assign cons = outValid & out_ready;

  // The output register is loaded from the input when it is free or being freed.
  // It is loaded from the skid entry when that entry exists and the head is consumed.
  // In TWO, in_ready is 0, so these two cases never overlap.
  assign loadSkid = (SKID == 1) & acc & outValid & ~cons;
  assign loadOut  = (acc & (~outValid | cons)) | (cons & skidValid);

  always_comb begin
    skidValidNxt = skidValid ? ~cons : loadSkid;
    outValidNxt  = skidValid | acc | (outValid & ~cons);
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
      inReadyQ  <= 1'b1;
    end else begin
      outValid  <= outValidNxt;
      skidValid <= skidValidNxt;
      inReadyQ  <= ~skidValidNxt;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : gLane
    pipe_stage_lane #(
      .W(LANE_W), .PASS(PASS_MASK[i]), .ZERO_BUBBLE(ZERO_BUBBLE)
    ) uLane (
      .clk(clk), .kill(kill), .loadOut(loadOut), .loadSkid(loadSkid),
      .selSkid(skidValid), .outValid(outValid),
      .inD(in_data[i*LANE_W +: LANE_W]), .outD(out_data[i*LANE_W +: LANE_W])
    );
  end

  pipe_stage_lane #(.W(AUX_W), .PASS(1'b0), .ZERO_BUBBLE(ZERO_BUBBLE)) uAux (
    .clk(clk), .kill(kill), .loadOut(loadOut), .loadSkid(loadSkid),
    .selSkid(skidValid), .outValid(outValid), .inD(in_aux), .outD(out_aux)
  );

  assign out_valid = outValid;
  assign occupancy = {1'b0, outValid} + {1'b0, skidValid};
endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, inValid, outReady;
  logic [127:0] inData;
  logic [1:0] inAux;

  // u0: SKID=1 (default), u1: SKID=0. Both get the same stimulus.
  logic rdy0, vld0, rdy1, vld1;
  logic [127:0] dat0, dat1;
  logic [1:0] aux0, aux1, occ0, occ1;

  pipe_stage_reg u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(rdy0),
    .in_data(inData), .in_aux(inAux), .out_valid(vld0), .out_ready(outReady),
    .out_data(dat0), .out_aux(aux0), .occupancy(occ0)
  );

  pipe_stage_reg #(.SKID(0)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(rdy1),
    .in_data(inData), .in_aux(inAux), .out_valid(vld1), .out_ready(outReady),
    .out_data(dat1), .out_aux(aux1), .occupancy(occ1)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the edge. Checks run from there, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane(input logic [127:0] d, input int i);
    return d[i*32 +: 32];
  endfunction

  function automatic logic [127:0] mk(input logic [31:0] l3, input logic [31:0] l0);
    return {l3, 32'h0000_00c2, 32'h0000_00b1, l0};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b1; outReady = 1'b0;
    inAux = 2'b11; inData = mk(32'h0040_0004, 32'haa);
    #1;

    // 1: reset
    tick();
    chk("rst_valid", vld0, 1'b0);
    chk("rst_l0", lane(dat0, 0), 32'h0);
    chk("rst_l1", lane(dat0, 1), 32'h0);
    chk("rst_l2", lane(dat0, 2), 32'h0);
    chk("rst_l3_pass", lane(dat0, 3), 32'h0040_0004);
    chk("rst_aux", aux0, 2'b00);
    chk("rst_occ", occ0, 2'd0);
    chk("rst_u1_l3_pass", lane(dat1, 3), 32'h0040_0004);
    rst = 1'b0; inValid = 1'b0;
    #1;
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_u1_ready", rdy1, 1'b1);

    // 2: streaming A,B,C with out_ready=1
    outReady = 1'b1; inValid = 1'b1; inAux = 2'b01;
    inData = mk(32'h100, 32'h11);
    tick();
    chk("strm_valid_a", vld0, 1'b1);
    chk("strm_a", lane(dat0, 0), 32'h11);
    chk("strm_aux_a", aux0, 2'b01);
    chk("strm_rdy_a", rdy0, 1'b1);
    inData = mk(32'h104, 32'h22);
    tick();
    chk("strm_b", lane(dat0, 0), 32'h22);
    chk("strm_rdy_b", rdy0, 1'b1);
    inData = mk(32'h108, 32'h33);
    tick();
    chk("strm_c", lane(dat0, 0), 32'h33);
    chk("strm_l3_c", lane(dat0, 3), 32'h108);
    inValid = 1'b0;
    tick();
    chk("bub_valid", vld0, 1'b0);
    chk("bub_l0_nop", lane(dat0, 0), 32'h0);
    chk("bub_aux", aux0, 2'b00);
    chk("bub_occ", occ0, 2'd0);

    // 3: stall fill, then drain in FIFO order
    outReady = 1'b0; inValid = 1'b1; inAux = 2'b10;
    inData = mk(32'h200, 32'ha1);
    tick();
    chk("stl_occ1", occ0, 2'd1);
    chk("stl_rdy1", rdy0, 1'b1);
    inData = mk(32'h204, 32'hb2);
    tick();
    chk("stl_occ2", occ0, 2'd2);
    chk("stl_rdy2", rdy0, 1'b0);
    chk("stl_hold_a", lane(dat0, 0), 32'ha1);
    inData = mk(32'h208, 32'hc3);
    tick();
    chk("stl_occ2_hold", occ0, 2'd2);
    chk("stl_hold_a2", lane(dat0, 0), 32'ha1);
    chk("stl_hold_aux", aux0, 2'b10);
    outReady = 1'b1;
    tick();
    chk("drn_b", lane(dat0, 0), 32'hb2);
    chk("drn_occ_b", occ0, 2'd1);
    chk("drn_rdy_b", rdy0, 1'b1);
    tick();
    chk("drn_c", lane(dat0, 0), 32'hc3);
    chk("drn_occ_c", occ0, 2'd1);
    inValid = 1'b0;
    tick();
    chk("drn_empty", occ0, 2'd0);
    chk("drn_valid", vld0, 1'b0);

    // 4: flush with occupancy=2 and an incoming datum
    outReady = 1'b0; inValid = 1'b1;
    inData = mk(32'h300, 32'hd4);
    tick();
    inData = mk(32'h304, 32'he5);
    tick();
    chk("fl_pre_occ", occ0, 2'd2);
    flush = 1'b1; inData = mk(32'h308, 32'hf6);
    tick();
    chk("fl_occ", occ0, 2'd0);
    chk("fl_valid", vld0, 1'b0);
    chk("fl_instr", lane(dat0, 0), 32'h0);
    chk("fl_rdy", rdy0, 1'b1);
    chk("fl_l3_pass", lane(dat0, 3), 32'h308);
    flush = 1'b0; inValid = 1'b0;
    tick();
    chk("fl_dropped", occ0, 2'd0);

    // 5: SKID=0 stall and same-cycle release
    rst = 1'b1;
    tick();
    rst = 1'b0; outReady = 1'b0; inValid = 1'b1;
    inData = mk(32'h400, 32'h55);
    #1;
    chk("s0_rdy_empty", rdy1, 1'b1);
    tick();
    chk("s0_valid", vld1, 1'b1);
    chk("s0_d55", lane(dat1, 0), 32'h55);
    inData = mk(32'h404, 32'h66);
    #1;
    chk("s0_rdy_stall", rdy1, 1'b0);
    chk("s0_occ", occ1, 2'd1);
    tick();
    chk("s0_hold", lane(dat1, 0), 32'h55);
    outReady = 1'b1;
    #1;
    chk("s0_rdy_release", rdy1, 1'b1);
    tick();
    chk("s0_d66", lane(dat1, 0), 32'h66);

    // 6: rst and flush together while aux=11 is held
    rst = 1'b1;
    tick();
    rst = 1'b0; outReady = 1'b0; inValid = 1'b1; inAux = 2'b11;
    inData = mk(32'h500, 32'h77);
    tick();
    chk("rf_pre_aux", aux0, 2'b11);
    rst = 1'b1; flush = 1'b1; inData = mk(32'h1234_5678, 32'h88);
    tick();
    chk("rf_aux", aux0, 2'b00);
    chk("rf_l3_pass", lane(dat0, 3), 32'h1234_5678);
    chk("rf_occ", occ0, 2'd0);
    chk("rf_l0", lane(dat0, 0), 32'h0);
    rst = 1'b0; flush = 1'b0; inValid = 1'b0;
    #1;
    chk("rf_rdy", rdy0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
